// File: rtl/mrr_pathway_output_arbiter.sv
// Merges per-pathway AXI-Stream words into one registered stream using
// packet-atomic round-robin arbitration; each beat is tagged with its source pathway.
module mrr_pathway_output_arbiter #(
  parameter int NUM_PATHWAYS      = 4,
  parameter int NUM_PATHWAYS_LOG2 = 2,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tkeep,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic                               o_tkeep,
  output logic                               o_tlast,
  output logic [NUM_PATHWAYS_LOG2-1:0]       o_tdest,
  output logic                               o_tvalid,
  input  logic                               o_tready,
  output logic [15:0]                        pkt_count,
  output logic                               busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                       state, state_next;
  logic [NUM_PATHWAYS_LOG2-1:0] grant, last_grant, pick;
  logic                         any_valid;
  logic                         out_free, accept;
  logic                         sel_valid, sel_keep, sel_last;
  logic [DATA_WIDTH-1:0]        sel_data;

  // Scan from farthest to nearest after last_grant so the nearest valid pathway wins.
  always_comb begin
    int                           idx;
    logic [NUM_PATHWAYS_LOG2-1:0] idx_l;
    pick      = last_grant;
    any_valid = 1'b0;
    for (int i = NUM_PATHWAYS; i >= 1; i--) begin
      idx   = (int'(last_grant) + i) % NUM_PATHWAYS;
      idx_l = NUM_PATHWAYS_LOG2'(idx);
      if (i_tvalid[idx_l]) begin
        pick      = idx_l;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_keep  = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NUM_PATHWAYS; k++) begin
      if (grant == NUM_PATHWAYS_LOG2'(k)) begin
        sel_data  = i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = i_tvalid[k];
        sel_keep  = i_tkeep[k];
        sel_last  = i_tlast[k];
      end
    end
  end

  // Valid/ready: a beat moves on any cycle where valid and ready are both high;
  // a source holds its beat stable until then, and ready never waits on valid.
  assign out_free = !o_tvalid || o_tready;
  assign accept   = (state == STREAM) && sel_valid && out_free;
  assign busy     = (state == STREAM);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    i_tready   = '0;
    case (state)
      IDLE: begin
        if (any_valid) state_next = STREAM;
      end
      STREAM: begin
        for (int k = 0; k < NUM_PATHWAYS; k++)
          i_tready[k] = out_free && (grant == NUM_PATHWAYS_LOG2'(k));
        if (accept && sel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= NUM_PATHWAYS_LOG2'(NUM_PATHWAYS - 1);
      o_tdata    <= '0;
      o_tkeep    <= 1'b0;
      o_tlast    <= 1'b0;
      o_tdest    <= '0;
      o_tvalid   <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (state == IDLE && any_valid) grant <= pick;
      if (accept && sel_last) last_grant <= grant;
      if (accept) begin
        o_tdata  <= sel_data;
        o_tkeep  <= sel_keep;
        o_tlast  <= sel_last;
        o_tdest  <= grant;
        o_tvalid <= 1'b1;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end
      if (o_tvalid && o_tready && o_tlast) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mrr_pathway_output_arbiter.sv
// Directed bench for mrr_pathway_output_arbiter: per-pathway packet sources,
// an expected-beat queue, cycle-exact latency/bubble checks and a final report.
module tb_mrr_pathway_output_arbiter;
  localparam int NP = 4;
  localparam int LG = 2;
  localparam int DW = 32;
  localparam int SW = LG + 2 + DW;

  logic             clk, rst;
  logic [DW*NP-1:0] i_tdata;
  logic [NP-1:0]    i_tkeep, i_tlast, i_tvalid, i_tready;
  logic [DW-1:0]    o_tdata;
  logic             o_tkeep, o_tlast, o_tvalid, o_tready, busy;
  logic [LG-1:0]    o_tdest;
  logic [15:0]      pkt_count;

  mrr_pathway_output_arbiter #(.NUM_PATHWAYS(NP), .NUM_PATHWAYS_LOG2(LG), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast),
    .o_tdest(o_tdest), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_count(pkt_count), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;
  int cyc = 0;

  // source model
  int          src_left[NP], src_len[NP], src_beat[NP], src_pkt[NP];
  int          src_stall_at[NP], src_stall_cnt[NP];
  logic [31:0] src_base[NP];
  logic        src_keep[NP];

  // scoreboard
  logic [SW-1:0] exp_q[$];
  bit gap_chk  = 1'b0;
  bit have_last = 1'b0;
  int last_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < NP; k++) begin
      src_left[k] = 0; src_len[k] = 1; src_beat[k] = 0; src_pkt[k] = 0;
      src_stall_at[k] = -1; src_stall_cnt[k] = 0; src_base[k] = '0; src_keep[k] = 1'b0;
    end
  endtask

  function automatic bit src_stalled(int k);
    return src_stall_cnt[k] > 0 && src_beat[k] == src_stall_at[k];
  endfunction

  task automatic drive_src();
    for (int k = 0; k < NP; k++) begin
      logic v;
      v = src_left[k] > 0 && !src_stalled(k);
      i_tvalid[k] = v;
      i_tkeep[k]  = v & src_keep[k];
      i_tlast[k]  = v && (src_beat[k] == src_len[k] - 1);
      i_tdata[k*DW +: DW] = v ? src_base[k] + 32'(src_pkt[k] << 4) + 32'(src_beat[k]) : '0;
    end
  endtask

  task automatic update_src(input logic [NP-1:0] hs);
    for (int k = 0; k < NP; k++) begin
      if (hs[k]) begin
        if (src_beat[k] == src_len[k] - 1) begin
          src_beat[k] = 0; src_pkt[k]++; src_left[k]--;
        end else begin
          src_beat[k]++;
        end
      end else if (src_stalled(k)) begin
        src_stall_cnt[k]--;
      end
    end
  endtask

  task automatic add_pkts(input int k, input int n, input int len, input logic [31:0] base, input logic keep);
    src_left[k] = n; src_len[k] = len; src_beat[k] = 0; src_pkt[k] = 0;
    src_base[k] = base; src_keep[k] = keep;
  endtask

  task automatic push_pkt(input int k, input int p, input int nbeats, input int len, input logic [31:0] base, input logic keep);
    for (int b = 0; b < nbeats; b++)
      exp_q.push_back({LG'(k), keep, (b == len - 1), base + 32'(p << 4) + 32'(b)});
  endtask

  // one clock: score the output beat, advance sources on handshakes, redrive
  task automatic tick();
    logic [NP-1:0] hs;
    logic          out_hs, hold, r;
    logic [DW-1:0] hd;
    logic [SW-1:0] seen, exp_v;
    hs     = i_tvalid & i_tready;
    out_hs = o_tvalid & o_tready;
    hold   = o_tvalid & ~o_tready;
    hd     = o_tdata;
    r      = rst;
    if (hold) check_eq("stall_ready", i_tready, 0);
    if (out_hs) begin
      seen = {o_tdest, o_tkeep, o_tlast, o_tdata};
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", exp_q.size(), 1);
      end else begin
        exp_v = exp_q.pop_front();
        check_eq("beat", seen, exp_v);
      end
      if (gap_chk && have_last) check_eq("gap", cyc - last_cyc, 2);
      have_last = o_tlast;
      if (o_tlast) last_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
    if (hold && !r) begin
      check_eq("hold_data", o_tdata, hd);
      check_eq("hold_valid", o_tvalid, 1);
    end
    if (r) clear_src();
    else   update_src(hs);
    drive_src();
    #1;
  endtask

  function automatic bit src_empty();
    for (int k = 0; k < NP; k++) if (src_left[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0 && !o_tvalid && !busy && src_empty()) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_done"}, done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    drive_src();
    have_last = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int stall_seen;
    rst = 1'b1;
    o_tready = 1'b1;
    i_tdata = '0; i_tkeep = '0; i_tlast = '0; i_tvalid = '0;
    clear_src();
    #2;

    // reset state
    do_reset();
    check_eq("rst_tvalid", o_tvalid, 0);
    check_eq("rst_tdata", o_tdata, 0);
    check_eq("rst_tkeep", o_tkeep, 0);
    check_eq("rst_tlast", o_tlast, 0);
    check_eq("rst_tdest", o_tdest, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tready", i_tready, 0);

    // single pathway 2, 3 beats, cycle-exact latency
    add_pkts(2, 1, 3, 32'hA0, 1'b1);
    push_pkt(2, 0, 3, 3, 32'hA0, 1'b1);
    drive_src(); #1;
    check_eq("t0_busy", busy, 0);
    check_eq("t0_tready", i_tready, 0);
    tick();
    check_eq("t1_busy", busy, 1);
    check_eq("t1_tready", i_tready, 4'b0100);
    check_eq("t1_tvalid", o_tvalid, 0);
    tick();
    check_eq("t2_tvalid", o_tvalid, 1);
    check_eq("t2_tdata", o_tdata, 32'hA0);
    check_eq("t2_tdest", o_tdest, 2);
    tick();
    check_eq("t3_tdata", o_tdata, 32'hA1);
    tick();
    check_eq("t4_tdata", o_tdata, 32'hA2);
    check_eq("t4_tlast", o_tlast, 1);
    check_eq("t4_busy", busy, 0);
    tick();
    check_eq("t5_tvalid", o_tvalid, 0);
    check_eq("t5_pkt_count", pkt_count, 1);
    drain("single", 20);

    // fairness: all pathways offer two 2-beat packets; pathway 3 uses tkeep=0
    do_reset();
    for (int k = 0; k < NP; k++) add_pkts(k, 2, 2, 32'(k << 8), k != 3);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NP; k++) push_pkt(k, p, 2, 2, 32'(k << 8), k != 3);
    drive_src(); #1;
    gap_chk = 1'b1;
    drain("fair", 100);
    gap_chk = 1'b0;
    check_eq("fair_pkt_count", pkt_count, 8);

    // backpressure: o_tready 1,0,0,1 during a 4-beat packet from pathway 1
    do_reset();
    add_pkts(1, 1, 4, 32'h100, 1'b1);
    push_pkt(1, 0, 4, 4, 32'h100, 1'b1);
    drive_src(); #1;
    tick(); tick();
    o_tready = 1'b1; #1; tick();
    o_tready = 1'b0; #1; tick();
    check_eq("bp_ready_low", i_tready[1], 0);
    o_tready = 1'b0; #1; tick();
    o_tready = 1'b1; #1;
    drain("bp", 30);
    check_eq("bp_pkt_count", pkt_count, 1);

    // mid-packet stall on pathway 0 while pathway 3 waits
    do_reset();
    add_pkts(0, 1, 3, 32'h000, 1'b1);
    src_stall_at[0] = 1; src_stall_cnt[0] = 5;
    add_pkts(3, 1, 2, 32'h300, 1'b1);
    push_pkt(0, 0, 3, 3, 32'h000, 1'b1);
    push_pkt(3, 0, 2, 2, 32'h300, 1'b1);
    drive_src(); #1;
    stall_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (src_stalled(0)) begin
        stall_seen++;
        check_eq("stall_busy", busy, 1);
        check_eq("stall_grant", i_tready, 4'b0001);
      end
      if (exp_q.size() == 0 && !o_tvalid && src_empty()) break;
      tick();
    end
    check_eq("stall_cycles", stall_seen, 5);
    drain("stall", 10);
    check_eq("stall_pkt_count", pkt_count, 2);

    // reset during beat 2 of a 5-beat packet from pathway 2
    do_reset();
    add_pkts(0, 1, 1, 32'h0E0, 1'b1);
    push_pkt(0, 0, 1, 1, 32'h0E0, 1'b1);
    drive_src(); #1;
    drain("pre_rst", 20);
    check_eq("pre_rst_count", pkt_count, 1);
    add_pkts(2, 1, 5, 32'h200, 1'b1);
    push_pkt(2, 0, 2, 5, 32'h200, 1'b1);
    drive_src(); #1;
    for (int n = 0; n < 20; n++) begin
      if (src_beat[2] == 2) break;
      tick();
    end
    check_eq("rst_reach_beat2", src_beat[2], 2);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check_eq("mid_rst_tvalid", o_tvalid, 0);
    check_eq("mid_rst_count", pkt_count, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_left", exp_q.size(), 0);
    add_pkts(3, 1, 2, 32'h300, 1'b1);
    add_pkts(1, 1, 2, 32'h100, 1'b1);
    push_pkt(1, 0, 2, 2, 32'h100, 1'b1);
    push_pkt(3, 0, 2, 2, 32'h300, 1'b1);
    drive_src(); #1;
    tick();
    check_eq("post_rst_grant", i_tready, 4'b0010);
    drain("post_rst", 30);

    // counter wrap with a single-beat packet, tkeep=0
    do_reset();
    add_pkts(0, 1, 1, 32'h0F0, 1'b0);
    push_pkt(0, 0, 1, 1, 32'h0F0, 1'b0);
    drive_src(); #1;
    tick();
    check_eq("wrap_busy", busy, 1);
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    tick();
    check_eq("one_beat_idle", busy, 0);
    check_eq("one_beat_valid", o_tvalid, 1);
    check_eq("one_beat_last", o_tlast, 1);
    tick();
    check_eq("wrap_count", pkt_count, 0);
    drain("wrap", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
